cam_frame_capture: RTL and testbench
====================================

Name: cam_frame_capture

Overview:
- Capture front end for the camera path, between the camera pins (cam_pxlclk, cam_hsync, cam_vsync, cam_data) and the frame-buffer DMA that writes to SDRAM.
- Oversamples the camera bus in the system clock domain and assembles byte pairs into RGB565 pixels.
- Packs two pixels per 32-bit word and streams words out through a valid/ready interface with start-of-frame and end-of-line markers.
- Captures exactly one frame per start command.

Parameters:
- H_PIXELS, 640: pixels per line; must be even.
- V_LINES, 480: lines captured per frame; further lines are dropped.
- FIFO_DEPTH, 16: output FIFO depth in words; power of two.
- SYNC_STAGES, 2: synchroniser flops on each camera input.

Ports:
- clk  in  1  system clock; must be at least 4x cam_pxlclk.
- reset  in  1  synchronous, active-high reset.
- cam_pxlclk  in  1  camera pixel clock, asynchronous to clk.
- cam_hsync  in  1  line valid, active high.
- cam_vsync  in  1  frame sync, active high between frames.
- cam_data  in  10  camera data; bits [9:2] carry the byte, bits [1:0] are ignored.
- start  in  1  one-cycle pulse; arms capture of one frame.
- busy  out  1  high from an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse at end of the captured frame.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- line_err  out  1  sticky; a line ended with a byte count other than 2*H_PIXELS.
- out_data  out  32  pixel word; first pixel in [15:0], second pixel in [31:16].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- out_sof  out  1  qualifies the first word of the frame.
- out_eol  out  1  qualifies the last word of each line.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: all outputs 0, FSM in IDLE, FIFO empty, all counters 0.
- Synchronisation:
  - cam_pxlclk, cam_hsync, cam_vsync and cam_data[9:2] each pass through SYNC_STAGES flops.
  - A pixel-clock event is the synchronised sequence prev=0, now=1.
  - hsync and data are sampled on the event cycle.
  - vsync edges are detected from the synchronised vsync.
- FSM states:
  - IDLE: start moves to ARM, sets busy, and clears overflow and line_err.
  - ARM: vsync falling edge moves to CAPTURE; the line counter clears.
  - CAPTURE: vsync rising edge, or V_LINES lines completed, moves to DONE.
  - DONE: pulses frame_done for one cycle, clears busy, returns to IDLE.
  - start outside IDLE is ignored.
- Pixel assembly (CAPTURE, pixel event with hsync=1):
  - Even byte = pixel[15:8]; odd byte = pixel[7:0].
  - Two pixels form one word; the word is pushed to the FIFO on the cycle after the 4th byte event.
  - Bytes arriving with hsync=0 are discarded.
- End of line: a synchronised hsync falling edge ends the line.
  - If the byte count != 2*H_PIXELS, set line_err.
  - Byte and pixel counters clear; a partial word is discarded; the line counter increments.
- Markers:
  - out_eol=1 on the word containing pixel H_PIXELS-1.
  - out_sof=1 on the first word pushed in CAPTURE.
  - Both markers travel through the FIFO with the data (34-bit FIFO entry).
- Dropping:
  - Pixels beyond H_PIXELS within a line are dropped and also set line_err.
  - Lines beyond V_LINES are never captured, because the FSM has already left CAPTURE.
- FIFO:
  - Show-ahead; out_valid = !empty; a pop occurs when out_valid && out_ready.
  - Push while full drops the word and sets overflow.
  - Push and pop in the same cycle while full: the pop frees the slot and the push succeeds.
- Latency: from the cam_pxlclk rising edge carrying the 4th byte to out_valid=1 with the FIFO empty is exactly SYNC_STAGES+2 clk cycles.
- Reset mid-frame: FIFO flushed, FSM to IDLE, busy=0; no frame_done pulse.
- Frame end while FIFO is non-empty: frame_done still pulses; the remaining words drain normally.
- Sticky flags clear only on reset or an accepted start.

Decomposition:
- Package cam_capture_pkg:
  - state enum {IDLE, ARM, CAPTURE, DONE}
  - PIXEL_W=16, WORD_W=32, FIFO entry width 34
  - marker bit indices SOF_BIT=32, EOL_BIT=33
- Sub-module cam_word_fifo: single-clock, show-ahead, FIFO_DEPTH x 34, with full and empty flags.
- Everything else (synchronisers, edge detect, FSM, packer, counters) stays in cam_frame_capture.

Test Plan:
- Frame of 4 lines x 4 pixels (H_PIXELS=4, V_LINES=4), out_ready=1, bytes 0x00..0x1F → 8 words; the first is 0x0203_0001 with sof=1; eol on words 2, 4, 6 and 8; one frame_done pulse; busy falls with it.
- No start issued while the camera runs frames → out_valid stays 0 and busy stays 0.
- out_ready=0 for the whole 640x480 frame, FIFO_DEPTH=16 → exactly 16 words held, overflow=1; after start is re-armed, overflow=0.
- Line with 7 bytes instead of 8 (H_PIXELS=4) → line_err=1; the partial word is discarded; the next line's words are correct and eol is aligned.
- Reset asserted mid-CAPTURE after 3 words → the next cycle has out_valid=0 and busy=0, with no frame_done; a following start plus frame captures cleanly.
- start pulsed again during CAPTURE → ignored; exactly one frame is captured and exactly one frame_done pulse is produced.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// rtl/cam_capture_pkg.sv - shared types and constants for the camera frame capture path
package cam_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } cap_state_t;

    localparam int PIXEL_W = 16;
    localparam int WORD_W  = 32;
    localparam int ENTRY_W = 34;
    localparam int SOF_BIT = 32;
    localparam int EOL_BIT = 33;

endpackage

// File: rtl/cam_word_fifo.sv
// rtl/cam_word_fifo.sv - single-clock show-ahead word FIFO carrying pixel words with their markers
module cam_word_fifo
    import cam_capture_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees a slot, so a push against a full FIFO still lands.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, empty gates the read side.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cam_frame_capture.sv
// rtl/cam_frame_capture.sv - camera bus oversampler, RGB565 word packer and single-frame capture control
module cam_frame_capture
    import cam_capture_pkg::*;
#(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_pxlclk,
    input  logic              cam_hsync,
    input  logic              cam_vsync,
    input  logic [9:0]        cam_data,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              line_err,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol
);

    localparam int LINE_BYTES = 2 * H_PIXELS;
    localparam int BC_W       = $clog2(LINE_BYTES + 2);
    localparam int LC_W       = $clog2(V_LINES + 1);

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(LINE_BYTES - 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(LINE_BYTES);
    localparam logic [BC_W-1:0] BC_OVER = BC_W'(LINE_BYTES + 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(V_LINES - 1);

    logic [SYNC_STAGES-1:0] pxl_sync;
    logic [SYNC_STAGES-1:0] hs_sync;
    logic [SYNC_STAGES-1:0] vs_sync;
    logic [7:0]             data_sync [SYNC_STAGES];

    logic pxl_prev;
    logic hs_prev;
    logic vs_prev;
    logic pxl_now;
    logic hs_now;
    logic vs_now;
    logic [7:0] data_now;
    logic pxl_event;
    logic hs_fall;
    logic vs_rise;
    logic vs_fall;

    cap_state_t       state;
    logic [BC_W-1:0]  byte_cnt;
    logic [LC_W-1:0]  line_cnt;
    logic [WORD_W-1:0] word_acc;
    logic [WORD_W-1:0] push_word;
    logic             push_req;
    logic             push_sof;
    logic             push_eol;
    logic             sof_pending;

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               unused_low_bits;

    // The two LSBs of the camera bus carry nothing for an 8-bit sensor.
    assign unused_low_bits = ^cam_data[1:0];

    assign pxl_now  = pxl_sync[SYNC_STAGES-1];
    assign hs_now   = hs_sync[SYNC_STAGES-1];
    assign vs_now   = vs_sync[SYNC_STAGES-1];
    assign data_now = data_sync[SYNC_STAGES-1];

    assign pxl_event = pxl_now && !pxl_prev;
    assign hs_fall   = hs_prev && !hs_now;
    assign vs_rise   = vs_now && !vs_prev;
    assign vs_fall   = vs_prev && !vs_now;

    // Every camera input runs through the same number of flops so data stays aligned to its pixel clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_sync <= '0;
            hs_sync  <= '0;
            vs_sync  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync[i] <= '0;
            end
        end else begin
            pxl_sync     <= {pxl_sync[SYNC_STAGES-2:0], cam_pxlclk};
            hs_sync      <= {hs_sync[SYNC_STAGES-2:0], cam_hsync};
            vs_sync      <= {vs_sync[SYNC_STAGES-2:0], cam_vsync};
            data_sync[0] <= cam_data[9:2];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync[i] <= data_sync[i-1];
            end
        end
    end

    // Previous-cycle copies of the synchronised controls for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_prev <= 1'b0;
            hs_prev  <= 1'b0;
            vs_prev  <= 1'b0;
        end else begin
            pxl_prev <= pxl_now;
            hs_prev  <= hs_now;
            vs_prev  <= vs_now;
        end
    end

    // Capture FSM with the byte packer, line/byte counters and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            line_err    <= 1'b0;
            byte_cnt    <= '0;
            line_cnt    <= '0;
            word_acc    <= '0;
            push_word   <= '0;
            push_req    <= 1'b0;
            push_sof    <= 1'b0;
            push_eol    <= 1'b0;
            sof_pending <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            push_req   <= 1'b0;

            if (push_req && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ARM;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        line_err <= 1'b0;
                    end
                end

                ARM: begin
                    if (vs_fall) begin
                        state       <= CAPTURE;
                        line_cnt    <= '0;
                        byte_cnt    <= '0;
                        sof_pending <= 1'b1;
                    end
                end

                CAPTURE: begin
                    if (vs_rise) begin
                        state <= DONE;
                    end else if (hs_fall) begin
                        // Line boundary: any partial word is abandoned by restarting the byte count.
                        if (byte_cnt != BC_FULL) begin
                            line_err <= 1'b1;
                        end
                        byte_cnt <= '0;
                        line_cnt <= line_cnt + 1'b1;
                        if (line_cnt == LC_LAST) begin
                            state <= DONE;
                        end
                    end else if (pxl_event && hs_now) begin
                        if (byte_cnt >= BC_FULL) begin
                            // Excess pixels are dropped; the counter parks past the line length.
                            line_err <= 1'b1;
                            byte_cnt <= BC_OVER;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            case (byte_cnt[1:0])
                                2'd0: word_acc[15:8]  <= data_now;
                                2'd1: word_acc[7:0]   <= data_now;
                                2'd2: word_acc[31:24] <= data_now;
                                default: begin
                                    push_word   <= {word_acc[31:24], data_now, word_acc[15:0]};
                                    push_req    <= 1'b1;
                                    push_sof    <= sof_pending;
                                    push_eol    <= (byte_cnt == BC_LAST);
                                    sof_pending <= 1'b0;
                                end
                            endcase
                        end
                    end
                end

                default: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign fifo_din = {push_eol, push_sof, push_word};
    assign fifo_pop = out_valid && out_ready;

    cam_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout[WORD_W-1:0];
    assign out_sof   = fifo_dout[SOF_BIT];
    assign out_eol   = fifo_dout[EOL_BIT];

endmodule

// File: tb/tb_cam_frame_capture.sv
// tb/tb_cam_frame_capture.sv - scoreboard bench for cam_frame_capture with a frame-level reference model
module tb_cam_frame_capture;

    localparam int H_PIXELS    = 4;
    localparam int V_LINES     = 10;
    localparam int FIFO_DEPTH  = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LB          = 2 * H_PIXELS;

    logic        clk = 1'b0;
    logic        reset;
    logic        cam_pxlclk;
    logic        cam_hsync;
    logic        cam_vsync;
    logic [9:0]  cam_data;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic        line_err;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eol;

    int vectors = 0;
    int errors  = 0;
    int fd_cnt  = 0;
    int popped  = 0;
    int ready_mode = 1;

    logic [33:0] exp_q[$];
    logic [7:0]  fb[$];
    int          fl[$];
    bit          exp_line_err;
    event        fourth_rise;

    always #5 clk = ~clk;

    cam_frame_capture #(
        .H_PIXELS    (H_PIXELS),
        .V_LINES     (V_LINES),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cam_pxlclk (cam_pxlclk),
        .cam_hsync  (cam_hsync),
        .cam_vsync  (cam_vsync),
        .cam_data   (cam_data),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .line_err   (line_err),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eol    (out_eol)
    );

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Reference: words a frame should yield, from line lengths and bytes alone.
    function automatic void model_frame(input int max_words);
        int pos;
        int nw;
        int usable;
        logic [31:0] w32;
        pos = 0;
        nw  = 0;
        exp_line_err = 1'b0;
        for (int l = 0; l < fl.size(); l++) begin
            if (l < V_LINES) begin
                if (fl[l] != LB) exp_line_err = 1'b1;
                usable = (fl[l] < LB) ? fl[l] : LB;
                for (int w = 0; 4 * w + 3 < usable; w++) begin
                    w32 = {fb[pos+4*w+2], fb[pos+4*w+3], fb[pos+4*w], fb[pos+4*w+1]};
                    if (nw < max_words)
                        exp_q.push_back({(4 * w + 3 == LB - 1), (nw == 0), w32});
                    nw++;
                end
            end
            pos += fl[l];
        end
    endfunction

    function automatic void build_frame(input int nlines, input int mode);
        int lens[8] = '{8, 8, 8, 7, 9, 12, 5, 8};
        int len;
        fl.delete();
        fb.delete();
        for (int l = 0; l < nlines; l++) begin
            len = (mode == 0) ? LB : lens[$urandom_range(7)];
            fl.push_back(len);
            for (int b = 0; b < len; b++)
                fb.push_back((mode == 0) ? 8'(fb.size()) : 8'($urandom));
        end
    endfunction

    task automatic cam_byte(input logic hs, input logic [7:0] b, input bit mark);
        @(negedge clk);
        cam_pxlclk = 1'b0;
        cam_hsync  = hs;
        cam_data   = {b, 2'($urandom)};
        repeat (3) @(negedge clk);
        cam_pxlclk = 1'b1;
        if (mark) ->fourth_rise;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input bit mark);
        int pos;
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (8) @(negedge clk);
        pos = 0;
        for (int l = 0; l < fl.size(); l++) begin
            repeat (2) cam_byte(1'b0, 8'($urandom), 1'b0);
            for (int b = 0; b < fl[l]; b++)
                cam_byte(1'b1, fb[pos+b], mark && l == 0 && b == 3);
            pos += fl[l];
            @(negedge clk);
            cam_hsync  = 1'b0;
            cam_pxlclk = 1'b0;
            repeat (6) @(negedge clk);
        end
        cam_vsync = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4000; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Downstream ready pattern: always, never, or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom);
            endcase
        end
    end

    // Monitor: every accepted word is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {out_eol, out_sof, out_data}, 64'hdead_0000_0000);
                end else begin
                    check("word", {out_eol, out_sof, out_data}, exp_q.pop_front());
                end
                popped++;
            end
            if (frame_done) begin
                fd_cnt++;
                check("busy_with_done", busy, 1'b0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int fd0;
        int base;
        reset      = 1'b1;
        start      = 1'b0;
        cam_pxlclk = 1'b0;
        cam_hsync  = 1'b0;
        cam_vsync  = 1'b1;
        cam_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {overflow, line_err, frame_done}, 0);
        check("rst_data", out_data, 0);
        reset = 1'b0;

        // Known 4x4 frame with sequential bytes, plus latency to the first word.
        ready_mode = 1;
        build_frame(4, 0);
        model_frame(1000);
        pulse_start();
        check("busy_armed", busy, 1);
        fork
            send_frame(1'b1);
            begin
                @(fourth_rise);
                lat = 0;
                do begin
                    @(posedge clk);
                    #1;
                    lat++;
                end while (!out_valid && lat < 20);
                check("latency", lat, SYNC_STAGES + 2);
            end
        join
        wait_drain("drain_basic");
        check("fd_basic", fd_cnt, 1);
        check("busy_basic", busy, 0);
        check("flags_basic", {overflow, line_err}, 0);

        // Camera runs with no start: nothing may come out.
        ready_mode = 2;
        fd0 = fd_cnt;
        build_frame(4, 1);
        send_frame(1'b0);
        check("nostart_valid", out_valid, 0);
        check("nostart_busy", busy, 0);
        check("nostart_fd", fd_cnt, fd0);

        // Random frames with irregular lines and random backpressure.
        for (int f = 0; f < 3; f++) begin
            fd0 = fd_cnt;
            build_frame($urandom_range(2, 6), 1);
            model_frame(1000);
            pulse_start();
            send_frame(1'b0);
            wait_drain("drain_rand");
            check("fd_rand", fd_cnt, fd0 + 1);
            check("line_err_rand", line_err, exp_line_err);
        end

        // More lines than V_LINES: capture stops after V_LINES lines.
        fd0 = fd_cnt;
        build_frame(V_LINES + 2, 0);
        for (int i = 0; i < fb.size(); i++) fb[i] = 8'($urandom);
        model_frame(1000);
        pulse_start();
        send_frame(1'b0);
        wait_drain("drain_trunc");
        check("fd_trunc", fd_cnt, fd0 + 1);

        // Stalled downstream: FIFO keeps the first FIFO_DEPTH words and flags overflow.
        ready_mode = 0;
        build_frame(V_LINES, 0);
        model_frame(FIFO_DEPTH);
        pulse_start();
        send_frame(1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_valid", out_valid, 1);
        ready_mode = 1;
        wait_drain("drain_ovf");
        pulse_start();
        check("ovf_cleared", overflow, 0);
        build_frame(2, 0);
        model_frame(1000);
        send_frame(1'b0);
        wait_drain("drain_after_ovf");

        // Reset mid-capture after three words.
        fd0 = fd_cnt;
        build_frame(4, 0);
        for (int i = 0; i < fb.size(); i++) fb[i] = 8'($urandom);
        model_frame(1000);
        base = popped;
        pulse_start();
        fork
            send_frame(1'b0);
            begin
                for (int i = 0; i < 4000 && popped < base + 3; i++) @(posedge clk);
                check("mid_words", popped >= base + 3, 1);
                @(posedge clk);
                #1 reset = 1'b1;
                exp_q.delete();
                @(posedge clk);
                #1 reset = 1'b0;
                check("mid_rst_valid", out_valid, 0);
                check("mid_rst_busy", busy, 0);
            end
        join
        check("mid_rst_fd", fd_cnt, fd0);
        build_frame(4, 1);
        model_frame(1000);
        pulse_start();
        send_frame(1'b0);
        wait_drain("drain_post_rst");
        check("fd_post_rst", fd_cnt, fd0 + 1);

        // A second start during CAPTURE is ignored.
        fd0 = fd_cnt;
        ready_mode = 2;
        build_frame(4, 0);
        for (int i = 0; i < fb.size(); i++) fb[i] = 8'($urandom);
        model_frame(1000);
        pulse_start();
        fork
            send_frame(1'b0);
            begin
                repeat (300) @(posedge clk);
                pulse_start();
            end
        join
        wait_drain("drain_restart");
        check("fd_restart", fd_cnt, fd0 + 1);
        build_frame(3, 1);
        send_frame(1'b0);
        check("restart_not_armed", fd_cnt, fd0 + 1);
        check("restart_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
